// File: rtl/xnor_pop_pkg.sv
// Shared widths and helpers for the XNOR-popcount accumulator.
package xnor_pop_pkg;

  localparam int DEF_N      = 128;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_BEAT_W = 8;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Popcount of N bits ranges 0..N inclusive, hence N+1 codes.
  function automatic int pc_width(input int n);
    return clog2(n + 1);
  endfunction

  localparam int DEF_PC_W = pc_width(DEF_N);

endpackage

// File: rtl/xnor_popcount_tree.sv
// Combinational N-bit XNOR followed by a balanced pairwise adder tree.
module xnor_popcount_tree
  import xnor_pop_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]           xi,
  input  logic [N-1:0]           wi,
  output logic [pc_width(N)-1:0] pc
);

  localparam int PC_W = pc_width(N);

  logic [PC_W-1:0] lvl [N];

  // Reduced in place: at width w, node i reads nodes 2i and 2i+1, which are
  // always at or above i and so still hold the previous level's values.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lvl[i] = PC_W'(~(xi[i] ^ wi[i]));
    end
    for (int w = N / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
    pc = lvl[0];
  end

endmodule

// File: rtl/xnor_popcount_acc_pipe.sv
// Pipelined XNOR-popcount accumulator: popcount stage, accumulate stage and a
// valid/ready result register with threshold compare and saturation flag.
module xnor_popcount_acc_pipe
  import xnor_pop_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [N-1:0]      xi,
  input  logic [N-1:0]      wi,
  input  logic [ACC_W-1:0]  thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_sat,
  output logic              out_bit
);

  localparam int PC_W  = pc_width(N);
  localparam int SUM_W = ACC_W + 1;

  logic              en;
  logic [PC_W-1:0]   pc_nx;

  logic              v1;
  logic              last1;
  logic [PC_W-1:0]   pc_r;
  logic [ACC_W-1:0]  thr1;

  logic [ACC_W-1:0]  acc_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              first_q;
  logic              sat_q;

  logic [ACC_W-1:0]  base;
  logic [SUM_W-1:0]  sum_w;
  logic [ACC_W-1:0]  sum_c;
  logic              ovf;
  logic [BEAT_W-1:0] beats_nx;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  xnor_popcount_tree #(.N(N)) u_tree (
    .xi (xi),
    .wi (wi),
    .pc (pc_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      pc_r  <= '0;
      thr1  <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        pc_r  <= pc_nx;
        last1 <= in_last;
        thr1  <= thresh;
      end
    end
  end

  // One spare carry bit detects overflow; the result then clamps to all-ones.
  always_comb begin
    base     = first_q ? '0 : acc_q;
    sum_w    = {1'b0, base} + SUM_W'(pc_r);
    ovf      = sum_w[ACC_W];
    sum_c    = ovf ? '1 : sum_w[ACC_W-1:0];
    beats_nx = (first_q ? '0 : beat_cnt_q) + BEAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      beat_cnt_q <= '0;
      first_q    <= 1'b1;
      sat_q      <= 1'b0;
    end else if (en && v1) begin
      if (last1) begin
        first_q <= 1'b1;
        sat_q   <= 1'b0;
      end else begin
        acc_q      <= sum_c;
        beat_cnt_q <= beats_nx;
        first_q    <= 1'b0;
        sat_q      <= sat_q | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
      out_bit   <= 1'b0;
    end else if (en && v1 && last1) begin
      out_valid <= 1'b1;
      out_sum   <= sum_c;
      out_beats <= beats_nx;
      out_sat   <= sat_q | ovf;
      out_bit   <= (sum_c >= thr1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnor_popcount_acc_pipe.sv
// Randomised bench for xnor_popcount_acc_pipe: default instance plus an
// ACC_W=8 instance for the saturation case.
module tb_xnor_popcount_acc_pipe;

  localparam int N      = 128;
  localparam int ACC_W  = 16;
  localparam int BEAT_W = 8;
  localparam int S_ACC  = 8;

  typedef struct packed {
    logic [ACC_W-1:0]  sum;
    logic [BEAT_W-1:0] beats;
    logic              sat;
    logic              bitv;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_sat, out_bit;
  logic [N-1:0] xi, wi;
  logic [ACC_W-1:0] thresh, out_sum;
  logic [BEAT_W-1:0] out_beats;

  logic s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_sat, s_out_bit;
  logic [N-1:0] s_xi, s_wi;
  logic [S_ACC-1:0] s_thresh, s_out_sum;
  logic [BEAT_W-1:0] s_out_beats;

  int tests = 0;
  int fails = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int plan[$];

  always #5 clk = ~clk;

  xnor_popcount_acc_pipe #(.N(N), .ACC_W(ACC_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .xi(xi), .wi(wi), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_beats(out_beats), .out_sat(out_sat), .out_bit(out_bit)
  );

  xnor_popcount_acc_pipe #(.N(N), .ACC_W(S_ACC), .BEAT_W(BEAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_last(s_in_last), .xi(s_xi), .wi(s_wi), .thresh(s_thresh),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_sum(s_out_sum),
    .out_beats(s_out_beats), .out_sat(s_out_sat), .out_bit(s_out_bit)
  );

  always @(posedge clk)
    if (rst_n && out_valid && out_ready)
      got_q.push_back({out_sum, out_beats, out_sat, out_bit});

  function automatic logic [N-1:0] rnd_n();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] ones_mask(input int k);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i < k);
    return m;
  endfunction

  // Reference: vector result is the plain sum of per-beat match counts,
  // clamped to the accumulator range; beats count modulo 2^BEAT_W.
  function automatic res_t model(input int total, input int nb, input logic [ACC_W-1:0] th);
    res_t r;
    int mx;
    int c;
    mx = (1 << ACC_W) - 1;
    c = (total > mx) ? mx : total;
    r.sum   = c[ACC_W-1:0];
    r.beats = nb[BEAT_W-1:0];
    r.sat   = (total > mx);
    r.bitv  = (c >= int'(th));
    return r;
  endfunction

  task automatic send_beat(input logic [N-1:0] x, input logic [N-1:0] w,
                           input logic last, input logic [ACC_W-1:0] th);
    int guard;
    logic acc_ok;
    guard = 0;
    acc_ok = 1'b0;
    in_valid = 1'b1; xi = x; wi = w; in_last = last; thresh = th;
    do begin
      @(negedge clk);
      acc_ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc_ok && guard < 200);
    in_valid = 1'b0; xi = rnd_n(); wi = rnd_n(); in_last = 1'($urandom); thresh = ACC_W'($urandom);
    if (!acc_ok) begin
      tests++; fails++;
      $display("FAIL send_beat: beat not accepted within %0d cycles", guard);
    end
  endtask

  task automatic send_vec(input int nb, input logic [ACC_W-1:0] th, input bit bub);
    int total;
    logic [N-1:0] x, w;
    total = 0;
    for (int b = 0; b < nb; b++) begin
      w = rnd_n();
      if (plan.size() > 0) x = w ^ ones_mask(N - plan.pop_front());
      else x = rnd_n();
      total += $countones(~(x ^ w));
      send_beat(x, w, b == nb - 1, (b == nb - 1) ? th : ACC_W'($urandom));
      if (bub && b < nb - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    exp_q.push_back(model(total, nb, th));
  endtask

  task automatic wait_results(input int n, output bit ok);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 100) begin @(posedge clk); #1; guard++; end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      in_valid = 1'($urandom); xi = rnd_n(); wi = rnd_n(); in_last = 1'($urandom);
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || out_sum !== '0) begin
        fails++; $display("FAIL reset_hold: out_valid=%0b out_sum=%0d want 0/0", out_valid, out_sum);
      end
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_beats !== '0 || s_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b out_beats=%0d s_out_valid=%0b want 1/0/0/0",
               in_ready, out_valid, out_beats, s_out_valid);
    end
    got_q.delete();
  endtask

  task automatic test_single_latency();
    logic [N-1:0] w;
    bit ok;
    res_t e, g;
    w = rnd_n();
    in_valid = 1'b1; xi = w; wi = w; in_last = 1'b1; thresh = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL latency_early: out_valid=%0b want 0 one clk after acceptance", out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== ACC_W'(N) || out_beats !== BEAT_W'(1)) begin
      fails++;
      $display("FAIL latency_single: out_valid=%0b sum=%0d beats=%0d want 1/%0d/1", out_valid, out_sum, out_beats, N);
    end
    @(posedge clk); #1;
    got_q.delete();
    plan.push_back(0);
    send_vec(1, ACC_W'(1), 0);
    wait_results(exp_q.size(), ok);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL single_zero: got sum=%0d beats=%0d sat=%0b bit=%0b want sum=%0d beats=%0d sat=%0b bit=%0b",
                 g.sum, g.beats, g.sat, g.bitv, e.sum, e.beats, e.sat, e.bitv);
      end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL single_zero_timeout: results=%0d want=1", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_four_beats();
    bit ok;
    res_t e, g;
    int total;
    for (int t = 100; t <= 101; t++) begin
      plan = '{10, 20, 30, 40};
      send_vec(4, ACC_W'(t), 1);
      total = 10 + 20 + 30 + 40;
      tests++;
      if (exp_q[0].sum !== ACC_W'(total)) begin
        fails++; $display("FAIL four_model: model sum=%0d want %0d", exp_q[0].sum, total);
      end
      wait_results(1, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL four_timeout: results=%0d want=1", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL four_beats(th=%0d): got sum=%0d beats=%0d sat=%0b bit=%0b want sum=%0d beats=%0d sat=%0b bit=%0b",
                   t, g.sum, g.beats, g.sat, g.bitv, e.sum, e.beats, e.sat, e.bitv);
        end
      end
      exp_q.delete(); got_q.delete();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int guard;
    res_t e, g;
    out_ready = 1'b0;
    send_vec(2, ACC_W'($urandom_range(0, 300)), 0);
    guard = 0;
    while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    fork
      send_vec(3, ACC_W'($urandom_range(0, 300)), 0);
      begin
        repeat (5) begin
          @(posedge clk); #1;
          tests++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== exp_q[0].sum) begin
            fails++;
            $display("FAIL backpressure_hold: in_ready=%0b out_valid=%0b sum=%0d want 0/1/%0d",
                     in_ready, out_valid, out_sum, exp_q[0].sum);
          end
        end
        #1 out_ready = 1'b1;
      end
    join
    wait_results(2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL backpressure_timeout: results=%0d want=2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL backpressure: got sum=%0d beats=%0d sat=%0b bit=%0b want sum=%0d beats=%0d sat=%0b bit=%0b",
                 g.sum, g.beats, g.sat, g.bitv, e.sum, e.beats, e.sat, e.bitv);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stream(input int nvec, input bit bub, input string name);
    bit ok;
    int n;
    res_t e, g;
    for (int v = 0; v < nvec; v++)
      send_vec($urandom_range(1, 5), ACC_W'($urandom_range(0, 400)), bub);
    n = exp_q.size();
    wait_results(n, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_timeout: results=%0d want=%0d", name, got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s: got sum=%0d beats=%0d sat=%0b bit=%0b want sum=%0d beats=%0d sat=%0b bit=%0b",
                 name, g.sum, g.beats, g.sat, g.bitv, e.sum, e.beats, e.sat, e.bitv);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_saturation();
    logic [N-1:0] w;
    int total, mx, c, guard;
    mx = (1 << S_ACC) - 1;
    for (int v = 0; v < 2; v++) begin
      int nb;
      nb = (v == 0) ? 3 : 1;
      total = 0;
      s_thresh = (v == 0) ? S_ACC'(0) : S_ACC'(6);
      for (int b = 0; b < nb; b++) begin
        w = rnd_n();
        s_wi = w;
        s_xi = (v == 0) ? w : (w ^ ones_mask(N - 5));
        total += $countones(~(s_xi ^ s_wi));
        s_in_last = (b == nb - 1);
        s_in_valid = 1'b1;
        @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      guard = 0;
      while (!s_out_valid && guard < 10) begin @(posedge clk); #1; guard++; end
      c = (total > mx) ? mx : total;
      tests++;
      if (s_out_valid !== 1'b1 || s_out_sum !== S_ACC'(c) || s_out_sat !== (total > mx) ||
          s_out_beats !== BEAT_W'(nb) || s_out_bit !== (c >= int'(s_thresh))) begin
        fails++;
        $display("FAIL saturation_%0d: valid=%0b sum=%0d sat=%0b beats=%0d bit=%0b want 1/%0d/%0b/%0d/%0b",
                 v, s_out_valid, s_out_sum, s_out_sat, s_out_beats, s_out_bit,
                 c, total > mx, nb, c >= int'(s_thresh));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_vector();
    bit ok;
    res_t e, g;
    for (int b = 0; b < 2; b++) send_beat(rnd_n(), rnd_n(), 1'b0, ACC_W'($urandom));
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    plan.push_back(7);
    send_vec(1, ACC_W'(7), 0);
    wait_results(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL reset_mid_timeout: results=%0d want=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e || g.sum !== ACC_W'(7) || g.beats !== BEAT_W'(1)) begin
        fails++;
        $display("FAIL reset_mid: got sum=%0d beats=%0d sat=%0b bit=%0b want sum=7 beats=1 sat=0 bit=1",
                 g.sum, g.beats, g.sat, g.bitv);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    in_valid = 1'b0; in_last = 1'b0; xi = '0; wi = '0; thresh = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_xi = '0; s_wi = '0; s_thresh = '0;
    test_reset();
    test_single_latency();
    test_four_beats();
    test_backpressure();
    test_stream(6, 0, "back_to_back");
    test_stream(10, 1, "random_bubbles");
    test_saturation();
    test_reset_mid_vector();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
